// File: rtl/cricket_pkg.sv
// Shared codes for the cricket scoring pipeline: delivery types,
// tracker FSM states and default over/innings limits.
package cricket_pkg;

    typedef enum logic [2:0] {
        BT_LEGAL   = 3'd0,
        BT_BYE     = 3'd1,
        BT_WIDE    = 3'd2,
        BT_NO_BALL = 3'd3,
        BT_DEAD    = 3'd4
    } ball_type_e;

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_OVER_END = 2'd1,
        ST_DONE     = 2'd2
    } state_e;

    localparam int DEF_BALLS_PER_OVER = 6;
    localparam int DEF_MAX_WICKETS    = 10;
    localparam int DEF_RUN_W          = 6;

endpackage

// File: rtl/sat_adder.sv
// Unsigned add of a narrow increment onto a W-bit accumulator,
// clamping at all-ones instead of wrapping.
module sat_adder #(
    parameter int W  = 6,
    parameter int BW = 4
) (
    input  logic [W-1:0]  a_i,
    input  logic [BW-1:0] b_i,
    output logic [W-1:0]  y_o
);

    localparam int SW = ((W > BW) ? W : BW) + 1;

    logic [SW-1:0] sum;

    assign sum = SW'(a_i) + SW'(b_i);
    assign y_o = (sum > SW'({W{1'b1}})) ? {W{1'b1}} : sum[W-1:0];

endmodule

// File: rtl/ball_event_tracker.sv
// Per-delivery scoring tracker: accumulates the current over and
// emits the over_complete pulse consumed by over_counter.
module ball_event_tracker
    import cricket_pkg::*;
#(
    parameter int BALLS_PER_OVER = DEF_BALLS_PER_OVER,
    parameter int MAX_WICKETS    = DEF_MAX_WICKETS,
    parameter int RUN_W          = DEF_RUN_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ball_valid,
    output logic             ball_ready,
    input  logic [2:0]       ball_type,
    input  logic [2:0]       runs,
    input  logic             wicket,
    output logic [2:0]       balls_in_over,
    output logic [RUN_W-1:0] runs_this_over,
    output logic [RUN_W-1:0] extras_this_over,
    output logic [3:0]       wickets,
    output logic             free_hit,
    output logic             over_complete,
    output logic             maiden,
    output logic             innings_done
);

    state_e           state_q;
    logic [2:0]       balls_q;
    logic [RUN_W-1:0] runs_q;
    logic [RUN_W-1:0] extras_q;
    logic [3:0]       wkts_q;
    logic             fh_q;

    logic             accept;
    logic             is_counted;
    logic             set_fh;
    logic [3:0]       add_runs;
    logic [3:0]       add_ext;
    logic [RUN_W-1:0] runs_d;
    logic [RUN_W-1:0] extras_d;
    logic [3:0]       wkts_d;
    logic [2:0]       balls_d;
    logic             wkt_hit;

    assign ball_ready = (state_q == ST_NORMAL);
    assign accept     = ball_valid & ball_ready;

    always_comb begin
        is_counted = 1'b0;
        set_fh     = 1'b0;
        add_runs   = 4'd0;
        add_ext    = 4'd0;
        unique case (ball_type)
            BT_LEGAL: begin
                is_counted = 1'b1;
                add_runs   = {1'b0, runs};
            end
            BT_BYE: begin
                is_counted = 1'b1;
                add_runs   = {1'b0, runs};
                add_ext    = {1'b0, runs};
            end
            BT_WIDE: begin
                add_runs = {1'b0, runs} + 4'd1;
                add_ext  = {1'b0, runs} + 4'd1;
            end
            BT_NO_BALL: begin
                add_runs = {1'b0, runs} + 4'd1;
                add_ext  = 4'd1;
                set_fh   = 1'b1;
            end
            default: ;
        endcase
    end

    sat_adder #(.W(RUN_W), .BW(4)) u_runs_add (
        .a_i (runs_q),
        .b_i (add_runs),
        .y_o (runs_d)
    );

    sat_adder #(.W(RUN_W), .BW(4)) u_ext_add (
        .a_i (extras_q),
        .b_i (add_ext),
        .y_o (extras_d)
    );

    // A wicket off a free hit does not count.
    assign wkt_hit = is_counted & wicket & ~fh_q;
    assign wkts_d  = wkts_q + {3'd0, wkt_hit};
    assign balls_d = balls_q + {2'd0, is_counted};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_NORMAL;
            balls_q  <= '0;
            runs_q   <= '0;
            extras_q <= '0;
            wkts_q   <= '0;
            fh_q     <= 1'b0;
        end else begin
            unique case (state_q)
                ST_NORMAL: begin
                    if (accept) begin
                        balls_q  <= balls_d;
                        runs_q   <= runs_d;
                        extras_q <= extras_d;
                        wkts_q   <= wkts_d;
                        if (is_counted) begin
                            fh_q <= 1'b0;
                        end else if (set_fh) begin
                            fh_q <= 1'b1;
                        end
                        if (wkt_hit && wkts_d == 4'(MAX_WICKETS)) begin
                            state_q <= ST_DONE;
                        end else if (is_counted &&
                                     balls_d == 3'(BALLS_PER_OVER)) begin
                            state_q <= ST_OVER_END;
                        end
                    end
                end
                ST_OVER_END: begin
                    balls_q  <= '0;
                    runs_q   <= '0;
                    extras_q <= '0;
                    state_q  <= ST_NORMAL;
                end
                default: ;
            endcase
        end
    end

    // A reset arriving during the over-end cycle suppresses the pulse.
    assign over_complete    = (state_q == ST_OVER_END) & ~reset;
    assign maiden           = over_complete & (runs_q == '0);
    assign innings_done     = (state_q == ST_DONE);
    assign balls_in_over    = balls_q;
    assign runs_this_over   = runs_q;
    assign extras_this_over = extras_q;
    assign wickets          = wkts_q;
    assign free_hit         = fh_q;

endmodule
